// File: rtl/ms_sched.sv
// Mushroom spawn scheduler: spawns, rises, walks and retires power-up slots.
// Ports: sys_clk/RST_N, tick, blk_hit+blk_x/y, char_X/Y, bg_pos, rd_idx -> rd_x/y/en, grow, drop, busy_cnt.
module ms_sched #(
  parameter int         NSLOT      = 4,
  parameter int         RISE_TICKS = 12,
  parameter logic [9:0] X_LIMIT    = 10'd1000
) (
  input  logic                     sys_clk,
  input  logic                     RST_N,
  input  logic                     tick,
  input  logic                     blk_hit,
  input  logic [9:0]               blk_x,
  input  logic [9:0]               blk_y,
  input  logic [9:0]               char_X,
  input  logic [9:0]               char_Y,
  input  logic [9:0]               bg_pos,
  input  logic [$clog2(NSLOT)-1:0] rd_idx,
  output logic [9:0]               rd_x,
  output logic [9:0]               rd_y,
  output logic                     rd_en,
  output logic                     grow,
  output logic                     drop,
  output logic [$clog2(NSLOT):0]   busy_cnt
);

  localparam int         BW    = $clog2(NSLOT) + 1;
  localparam logic [3:0] RLAST = 4'(RISE_TICKS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RISE = 2'd1,
    S_WALK = 2'd2
  } st_e;

  typedef struct packed {
    st_e        st;
    logic [9:0] x;
    logic [9:0] y;
    logic [3:0] cnt;
  } slot_t;

  slot_t             slot_q [NSLOT];
  slot_t             slot_d [NSLOT];
  logic [NSLOT-1:0]  hit_v;
  logic              found;
  logic              grow_d;
  logic              drop_d;
  logic [BW-1:0]     cnt_d;

  function automatic logic [10:0] adiff(
    input logic [9:0] a,
    input logic [9:0] b
  );
    logic [10:0] ea;
    logic [10:0] eb;
    ea = {1'b0, a};
    eb = {1'b0, b};
    return (ea >= eb) ? ea - eb : eb - ea;
  endfunction

  always_ff @(posedge sys_clk or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NSLOT; i++) slot_q[i] <= '0;
      grow     <= 1'b0;
      drop     <= 1'b0;
      busy_cnt <= '0;
    end else begin
      for (int i = 0; i < NSLOT; i++) slot_q[i] <= slot_d[i];
      grow     <= grow_d;
      drop     <= drop_d;
      busy_cnt <= cnt_d;
    end
  end

  // Spawn only into slots idle in the registered state, so a slot freed
  // this cycle is never reused before the next edge.
  always_comb begin
    slot_d = slot_q;
    found  = 1'b0;
    hit_v  = '0;
    cnt_d  = '0;
    for (int i = 0; i < NSLOT; i++) begin
      hit_v[i] = (slot_q[i].st == S_WALK) &&
                 (adiff(char_X, slot_q[i].x) <= 11'd12) &&
                 (adiff(char_Y, slot_q[i].y) <= 11'd12);
      unique case (1'b1)
        hit_v[i]: slot_d[i] = '0;
        (slot_q[i].st == S_WALK) && tick && !hit_v[i]: begin
          if (({1'b0, slot_q[i].x} + 11'd1) >= {1'b0, X_LIMIT})
            slot_d[i] = '0;
          else
            slot_d[i].x = slot_q[i].x + 10'd1;
        end
        (slot_q[i].st == S_RISE) && tick: begin
          slot_d[i].y   = (slot_q[i].y == 10'd0) ? 10'd0
                                                 : slot_q[i].y - 10'd1;
          slot_d[i].cnt = slot_q[i].cnt + 4'd1;
          slot_d[i].st  = (slot_q[i].cnt == RLAST) ? S_WALK : S_RISE;
        end
        (slot_q[i].st == S_IDLE) && blk_hit && !found: begin
          slot_d[i].st  = S_RISE;
          slot_d[i].x   = blk_x;
          slot_d[i].y   = blk_y;
          slot_d[i].cnt = 4'd0;
        end
        default: ;
      endcase
      if (slot_q[i].st == S_IDLE) found = 1'b1;
    end
    for (int i = 0; i < NSLOT; i++)
      if (slot_d[i].st != S_IDLE) cnt_d = cnt_d + BW'(1);
    grow_d = |hit_v;
    drop_d = blk_hit && !found;
  end

  always_comb begin
    rd_en = 1'b0;
    rd_x  = '0;
    rd_y  = '0;
    if (int'(rd_idx) < NSLOT && slot_q[rd_idx].st != S_IDLE) begin
      rd_en = 1'b1;
      rd_x  = slot_q[rd_idx].x - bg_pos;
      rd_y  = slot_q[rd_idx].y;
    end
  end

endmodule

// File: tb/tb_ms_sched.sv
// Scoreboard bench for ms_sched: directed steps push expectations,
// a monitor pops and compares one record per clock.
module tb_ms_sched;

  logic       sys_clk = 1'b0;
  logic       RST_N   = 1'b0;
  logic       tick    = 1'b0;
  logic       blk_hit = 1'b0;
  logic [9:0] blk_x   = '0;
  logic [9:0] blk_y   = '0;
  logic [9:0] char_X  = '0;
  logic [9:0] char_Y  = 10'd1000;
  logic [9:0] bg_pos  = '0;
  logic [1:0] rd_idx  = '0;
  logic [9:0] rd_x;
  logic [9:0] rd_y;
  logic       rd_en;
  logic       grow;
  logic       drop;
  logic [2:0] busy_cnt;

  ms_sched dut (
    .sys_clk (sys_clk),
    .RST_N   (RST_N),
    .tick    (tick),
    .blk_hit (blk_hit),
    .blk_x   (blk_x),
    .blk_y   (blk_y),
    .char_X  (char_X),
    .char_Y  (char_Y),
    .bg_pos  (bg_pos),
    .rd_idx  (rd_idx),
    .rd_x    (rd_x),
    .rd_y    (rd_y),
    .rd_en   (rd_en),
    .grow    (grow),
    .drop    (drop),
    .busy_cnt(busy_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int         id;
    logic       g;
    logic       d;
    logic [2:0] b;
    logic       en;
    logic [9:0] x;
    logic [9:0] y;
  } exp_t;

  exp_t       q[$];
  exp_t       e;
  int         checks   = 0;
  int         failures = 0;
  int         step_id  = 0;
  logic [9:0] nxt_cx   = '0;
  logic [9:0] nxt_cy   = 10'd1000;
  logic [9:0] nxt_bg   = '0;
  logic [1:0] nxt_ri   = '0;

  task automatic chk(input string nm, input int id,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got=%0d want=%0d", nm, id, act, exp);
    end
  endtask

  task automatic cyc(input logic t, input logic h,
                     input logic [9:0] bx, input logic [9:0] by,
                     input logic g, input logic d, input logic [2:0] b,
                     input logic en, input logic [9:0] ex,
                     input logic [9:0] ey);
    exp_t r;
    @(negedge sys_clk);
    tick    = t;
    blk_hit = h;
    blk_x   = bx;
    blk_y   = by;
    char_X  = nxt_cx;
    char_Y  = nxt_cy;
    bg_pos  = nxt_bg;
    rd_idx  = nxt_ri;
    step_id++;
    r.id = step_id;
    r.g  = g;
    r.d  = d;
    r.b  = b;
    r.en = en;
    r.x  = ex;
    r.y  = ey;
    q.push_back(r);
  endtask

  task automatic chk_reset(input int id);
    chk("rst_grow", id, 32'(grow), 0);
    chk("rst_drop", id, 32'(drop), 0);
    chk("rst_busy", id, 32'(busy_cnt), 0);
    chk("rst_en", id, 32'(rd_en), 0);
    chk("rst_x", id, 32'(rd_x), 0);
    chk("rst_y", id, 32'(rd_y), 0);
  endtask

  always begin
    @(posedge sys_clk);
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("grow", e.id, 32'(grow), 32'(e.g));
      chk("drop", e.id, 32'(drop), 32'(e.d));
      chk("busy", e.id, 32'(busy_cnt), 32'(e.b));
      chk("rd_en", e.id, 32'(rd_en), 32'(e.en));
      chk("rd_x", e.id, 32'(rd_x), 32'(e.x));
      chk("rd_y", e.id, 32'(rd_y), 32'(e.y));
    end
  end

  initial begin
    repeat (2) @(negedge sys_clk);
    chk_reset(0);
    @(negedge sys_clk);
    RST_N = 1'b1;

    // spawn, rise 12 ticks, then walk
    cyc(0, 1, 300, 115, 0, 0, 1, 1, 300, 115);
    for (int k = 1; k <= 12; k++)
      cyc(1, 0, 0, 0, 0, 0, 1, 1, 300, 10'(115 - k));
    nxt_bg = 50;
    cyc(0, 0, 0, 0, 0, 0, 1, 1, 250, 103);
    nxt_bg = 0;
    nxt_cx = 313; nxt_cy = 100;
    cyc(0, 0, 0, 0, 0, 0, 1, 1, 300, 103);
    nxt_cx = 310;
    cyc(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    nxt_cx = 0; nxt_cy = 1000;

    // fill all slots, fifth hit dropped
    for (int k = 0; k < 4; k++)
      cyc(0, 1, 10'(100 + 10 * k), 200, 0, 0, 3'(k + 1), 1, 100, 200);
    cyc(0, 1, 140, 200, 0, 1, 4, 1, 100, 200);
    nxt_ri = 3;
    cyc(0, 0, 0, 0, 0, 0, 4, 1, 130, 200);
    nxt_ri = 2;
    for (int k = 1; k <= 12; k++)
      cyc(1, 0, 0, 0, 0, 0, 4, 1, 120, 10'(200 - k));

    // collision with same-cycle hit: freed slot not reused
    nxt_ri = 0; nxt_cx = 90; nxt_cy = 176;
    cyc(0, 1, 500, 500, 1, 1, 3, 0, 0, 0);
    nxt_cx = 0; nxt_cy = 1000;
    cyc(0, 1, 600, 400, 0, 0, 4, 1, 600, 400);

    // three slots collide at once
    nxt_cx = 120; nxt_cy = 188; nxt_ri = 2;
    cyc(0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
    nxt_cx = 0; nxt_cy = 1000; nxt_ri = 0;
    for (int k = 1; k <= 12; k++)
      cyc(1, 0, 0, 0, 0, 0, 1, 1, 600, 10'(400 - k));
    cyc(1, 0, 0, 0, 0, 0, 1, 1, 601, 388);

    // async reset mid-walk
    @(negedge sys_clk);
    tick = 1'b0;
    blk_hit = 1'b0;
    #2 RST_N = 1'b0;
    #1 chk_reset(step_id);
    @(negedge sys_clk);
    RST_N = 1'b1;
    cyc(0, 1, 400, 300, 0, 0, 1, 1, 400, 300);

    // spawn with tick, retire at X_LIMIT, y saturation, hit beats retire
    nxt_ri = 1;
    cyc(1, 1, 998, 50, 0, 0, 2, 1, 998, 50);
    for (int k = 1; k <= 12; k++)
      cyc(1, 0, 0, 0, 0, 0, 2, 1, 998, 10'(50 - k));
    cyc(1, 0, 0, 0, 0, 0, 2, 1, 999, 38);
    cyc(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    cyc(0, 1, 999, 5, 0, 0, 2, 1, 999, 5);
    for (int k = 1; k <= 12; k++)
      cyc(1, 0, 0, 0, 0, 0, 2, 1, 999, (k >= 5) ? 10'd0 : 10'(5 - k));
    nxt_cx = 999; nxt_cy = 0;
    cyc(1, 0, 0, 0, 1, 0, 1, 0, 0, 0);
    nxt_cx = 0; nxt_cy = 1000;
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);

    @(negedge sys_clk);
    tick = 1'b0;
    blk_hit = 1'b0;
    for (int w = 0; w < 10 && q.size() != 0; w++) @(negedge sys_clk);
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
